// File: rtl/pe_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  pe_cfg_pkg
//  Shared address map, control-bit positions and FSM encoding for the
//  per-PE double-buffered configuration bank.
//  Revision: 1.0  initial release
// ============================================================================
package pe_cfg_pkg;

    // Fixed word addresses at the bottom of the map
    localparam int ADDR_LAYER_NO = 0;
    localparam int ADDR_CTRL     = 1;
    localparam int ACT_BASE      = 4;

    // Control register bit positions
    localparam int CTRL_COMMIT  = 0;
    localparam int CTRL_CLR_ERR = 1;

    // Commit FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Field selected by a decoded address
    typedef enum logic [2:0] {
        FLD_NONE     = 3'd0,
        FLD_LAYER_NO = 3'd1,
        FLD_CTRL     = 3'd2,
        FLD_ACT      = 3'd3,
        FLD_COL      = 3'd4,
        FLD_WOFF     = 3'd5
    } cfg_field_e;

    // act_no has max_layers entries; col_dim / w_mem_offset have one fewer
    function automatic int col_base(input int max_layers);
        return ACT_BASE + max_layers;
    endfunction

    function automatic int woff_base(input int max_layers);
        return col_base(max_layers) + max_layers - 1;
    endfunction

    function automatic int addr_end(input int max_layers);
        return woff_base(max_layers) + max_layers - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_state_bank_if.sv
`default_nettype none
// ============================================================================
//  pe_state_bank_if
//  Configuration write (valid/ready) and readback bus of a PE state bank.
//  Revision: 1.0  initial release
// ============================================================================
interface pe_state_bank_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) ();
    logic              cfg_wr_valid;
    logic              cfg_wr_ready;
    logic [ADDR_W-1:0] cfg_wr_addr;
    logic [DATA_W-1:0] cfg_wr_data;
    logic              cfg_rd_valid;
    logic [ADDR_W-1:0] cfg_rd_addr;
    logic [DATA_W-1:0] cfg_rd_data;
    logic              cfg_rd_data_valid;

    // Host / configuration master side
    modport master (
        output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_rd_valid, cfg_rd_addr,
        input  cfg_wr_ready, cfg_rd_data, cfg_rd_data_valid
    );

    // State bank side
    modport slave (
        input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_rd_valid, cfg_rd_addr,
        output cfg_wr_ready, cfg_rd_data, cfg_rd_data_valid
    );
endinterface
`default_nettype wire

// File: rtl/pe_cfg_decode.sv
`default_nettype none
// ============================================================================
//  pe_cfg_decode
//  Combinational word-address decode into {field, index, hit}; one copy
//  serves the write path and one the read path.
//  Revision: 1.0  initial release
// ============================================================================
module pe_cfg_decode
    import pe_cfg_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int LNO_W      = 3,
    parameter int ADDR_W     = 6
) (
    input  wire logic [ADDR_W-1:0] addr_i,
    output cfg_field_e             field_o,
    output logic [LNO_W-1:0]       idx_o,
    output logic                   hit_o
);

    localparam logic [31:0] C_LNO  = 32'(ADDR_LAYER_NO);
    localparam logic [31:0] C_CTRL = 32'(ADDR_CTRL);
    localparam logic [31:0] C_ACT  = 32'(ACT_BASE);
    localparam logic [31:0] C_COL  = 32'(col_base(MAX_LAYERS));
    localparam logic [31:0] C_WOFF = 32'(woff_base(MAX_LAYERS));
    localparam logic [31:0] C_END  = 32'(addr_end(MAX_LAYERS));

    logic [31:0] w_addr;
    assign w_addr = {{(32-ADDR_W){1'b0}}, addr_i};

    // Range-compare the address against each region of the map
    always_comb begin
        field_o = FLD_NONE;
        idx_o   = '0;
        hit_o   = 1'b0;
        if (w_addr == C_LNO) begin
            field_o = FLD_LAYER_NO;
            hit_o   = 1'b1;
        end else if (w_addr == C_CTRL) begin
            field_o = FLD_CTRL;
            hit_o   = 1'b1;
        end else if (w_addr >= C_ACT && w_addr < C_COL) begin
            field_o = FLD_ACT;
            idx_o   = LNO_W'(w_addr - C_ACT);
            hit_o   = 1'b1;
        end else if (w_addr >= C_COL && w_addr < C_WOFF) begin
            field_o = FLD_COL;
            idx_o   = LNO_W'(w_addr - C_COL);
            hit_o   = 1'b1;
        end else if (w_addr >= C_WOFF && w_addr < C_END) begin
            field_o = FLD_WOFF;
            idx_o   = LNO_W'(w_addr - C_WOFF);
            hit_o   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_state_bank.sv
`default_nettype none
// ============================================================================
//  pe_state_bank
//  Double-buffered per-PE layer configuration: writes land in a shadow bank,
//  a commit copies it to the active bank once the datapath is idle, and the
//  active entries for the current layer are presented as registered outputs.
//  Revision: 1.0  initial release
// ============================================================================
module pe_state_bank
    import pe_cfg_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int LNO_W      = 3,
    parameter int ACT_W      = 6,
    parameter int COL_W      = 6,
    parameter int WOFF_W     = 10,
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [5:0]        pe_idx_i,
    pe_state_bank_if.slave         cfg,
    input  wire logic              dp_busy_i,
    output logic                   commit_done_o,
    output logic                   cfg_err_o,
    input  wire logic [LNO_W-1:0]  layer_idx_i,
    output logic [LNO_W-1:0]       layer_no_o,
    output logic [ACT_W-1:0]       in_act_no_o,
    output logic [ACT_W-1:0]       out_act_no_o,
    output logic [COL_W-1:0]       col_dim_o,
    output logic [WOFF_W-1:0]      w_mem_offset_o
);

    // Shadow bank (written by config port)
    logic [LNO_W-1:0]  sh_ln_q;
    logic [ACT_W-1:0]  sh_act_q  [MAX_LAYERS];
    logic [COL_W-1:0]  sh_col_q  [MAX_LAYERS-1];
    logic [WOFF_W-1:0] sh_woff_q [MAX_LAYERS-1];

    // Active bank (drives the PE)
    logic [LNO_W-1:0]  ac_ln_q;
    logic [ACT_W-1:0]  ac_act_q  [MAX_LAYERS];
    logic [COL_W-1:0]  ac_col_q  [MAX_LAYERS-1];
    logic [WOFF_W-1:0] ac_woff_q [MAX_LAYERS-1];

    logic [0:0]        state_q, state_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] w_rd_value;

    cfg_field_e        w_wr_field, w_rd_field;
    logic [LNO_W-1:0]  w_wr_idx, w_rd_idx;
    logic              w_wr_hit, w_rd_hit;

    pe_cfg_decode #(.MAX_LAYERS(MAX_LAYERS), .LNO_W(LNO_W), .ADDR_W(ADDR_W)) u_wr_dec (
        .addr_i  (cfg.cfg_wr_addr),
        .field_o (w_wr_field),
        .idx_o   (w_wr_idx),
        .hit_o   (w_wr_hit)
    );

    pe_cfg_decode #(.MAX_LAYERS(MAX_LAYERS), .LNO_W(LNO_W), .ADDR_W(ADDR_W)) u_rd_dec (
        .addr_i  (cfg.cfg_rd_addr),
        .field_o (w_rd_field),
        .idx_o   (w_rd_idx),
        .hit_o   (w_rd_hit)
    );

    logic w_wr_ready, w_wr_fire, w_commit_req, w_clr_req, w_commit_go, w_ln_ok, w_err_set;
    logic [31:0] w_ln32, w_li32;

    assign w_wr_ready   = (state_q == ST_IDLE);
    assign w_wr_fire    = cfg.cfg_wr_valid && w_wr_ready;
    assign w_commit_req = w_wr_fire && (w_wr_field == FLD_CTRL) && cfg.cfg_wr_data[CTRL_COMMIT];
    assign w_clr_req    = w_wr_fire && (w_wr_field == FLD_CTRL) && cfg.cfg_wr_data[CTRL_CLR_ERR];
    assign w_commit_go  = (state_q == ST_PEND) && !dp_busy_i;
    assign w_ln32       = {{(32-LNO_W){1'b0}}, sh_ln_q};
    assign w_li32       = {{(32-LNO_W){1'b0}}, layer_idx_i};
    assign w_ln_ok      = (w_ln32 != 32'd0) && (w_ln32 <= 32'(MAX_LAYERS-1));
    assign w_err_set    = (w_wr_fire && !w_wr_hit) || (cfg.cfg_rd_valid && !w_rd_hit)
                        || (w_commit_go && !w_ln_ok);

    // pe_idx only labels simulation messages; upper data bits are don't-care
    logic w_unused;
    assign w_unused = ^{pe_idx_i, cfg.cfg_wr_data};

    assign cfg.cfg_wr_ready      = w_wr_ready;
    assign cfg.cfg_rd_data       = rd_data_q;
    assign cfg.cfg_rd_data_valid = rd_valid_q;
    assign commit_done_o         = done_q;
    assign cfg_err_o             = err_q;

    // Commit FSM, sticky error (clear before set) and commit pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_commit_req) state_d = ST_PEND;
            ST_PEND: if (!dp_busy_i)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        err_d = err_q;
        if (w_clr_req) err_d = 1'b0;
        if (w_err_set) err_d = 1'b1;
        done_d = w_commit_go && w_ln_ok;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Shadow bank update on an accepted write to a data field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ln_q <= '0;
            for (int i = 0; i < MAX_LAYERS; i++)   sh_act_q[i]  <= '0;
            for (int i = 0; i < MAX_LAYERS-1; i++) sh_col_q[i]  <= '0;
            for (int i = 0; i < MAX_LAYERS-1; i++) sh_woff_q[i] <= '0;
        end else if (w_wr_fire) begin
            case (w_wr_field)
                FLD_LAYER_NO: sh_ln_q             <= cfg.cfg_wr_data[LNO_W-1:0];
                FLD_ACT:      sh_act_q[w_wr_idx]  <= cfg.cfg_wr_data[ACT_W-1:0];
                FLD_COL:      sh_col_q[w_wr_idx]  <= cfg.cfg_wr_data[COL_W-1:0];
                FLD_WOFF:     sh_woff_q[w_wr_idx] <= cfg.cfg_wr_data[WOFF_W-1:0];
                default:      ;
            endcase
        end
    end

    // Whole-bank copy shadow -> active in a single edge on a valid commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_ln_q <= '0;
            for (int i = 0; i < MAX_LAYERS; i++)   ac_act_q[i]  <= '0;
            for (int i = 0; i < MAX_LAYERS-1; i++) ac_col_q[i]  <= '0;
            for (int i = 0; i < MAX_LAYERS-1; i++) ac_woff_q[i] <= '0;
        end else if (w_commit_go && w_ln_ok) begin
            ac_ln_q   <= sh_ln_q;
            ac_act_q  <= sh_act_q;
            ac_col_q  <= sh_col_q;
            ac_woff_q <= sh_woff_q;
        end
    end

    // Readback mux over the shadow bank; address 1 reports {err, pending}
    always_comb begin
        w_rd_value = '0;
        case (w_rd_field)
            FLD_LAYER_NO: w_rd_value = {{(DATA_W-LNO_W){1'b0}}, sh_ln_q};
            FLD_CTRL:     w_rd_value = {{(DATA_W-2){1'b0}}, err_q, (state_q == ST_PEND)};
            FLD_ACT:      w_rd_value = {{(DATA_W-ACT_W){1'b0}}, sh_act_q[w_rd_idx]};
            FLD_COL:      w_rd_value = {{(DATA_W-COL_W){1'b0}}, sh_col_q[w_rd_idx]};
            FLD_WOFF:     w_rd_value = {{(DATA_W-WOFF_W){1'b0}}, sh_woff_q[w_rd_idx]};
            default:      w_rd_value = '0;
        endcase
    end

    // One-cycle readback pipeline; samples pre-write shadow contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= cfg.cfg_rd_valid;
            if (cfg.cfg_rd_valid) rd_data_q <= w_rd_value;
        end
    end

    // Registered per-layer view of the active bank with range guards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_no_o     <= '0;
            in_act_no_o    <= '0;
            out_act_no_o   <= '0;
            col_dim_o      <= '0;
            w_mem_offset_o <= '0;
        end else begin
            layer_no_o     <= ac_ln_q;
            in_act_no_o    <= (w_li32 < 32'(MAX_LAYERS)) ? ac_act_q[layer_idx_i] : '0;
            out_act_no_o   <= (w_li32 + 32'd1 < 32'(MAX_LAYERS))
                              ? ac_act_q[LNO_W'(w_li32 + 32'd1)] : '0;
            col_dim_o      <= (w_li32 < 32'(MAX_LAYERS-1)) ? ac_col_q[layer_idx_i]  : '0;
            w_mem_offset_o <= (w_li32 < 32'(MAX_LAYERS-1)) ? ac_woff_q[layer_idx_i] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_state_bank.sv
`default_nettype none
// ============================================================================
//  tb_pe_state_bank
//  Randomised self-checking bench; reference model keeps the shadow bank as
//  an address-indexed memory and the active bank as per-field arrays.
//  Revision: 1.0  initial release
// ============================================================================
module tb_pe_state_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] pe_idx = 6'd3;
    logic       dp_busy = 1'b0;
    logic [2:0] layer_idx = 3'd0;
    logic       commit_done, cfg_err;
    logic [2:0] layer_no;
    logic [5:0] in_act_no, out_act_no, col_dim;
    logic [9:0] w_mem_offset;

    pe_state_bank_if #(.ADDR_W(6), .DATA_W(16)) bus ();

    pe_state_bank dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pe_idx_i       (pe_idx),
        .cfg            (bus),
        .dp_busy_i      (dp_busy),
        .commit_done_o  (commit_done),
        .cfg_err_o      (cfg_err),
        .layer_idx_i    (layer_idx),
        .layer_no_o     (layer_no),
        .in_act_no_o    (in_act_no),
        .out_act_no_o   (out_act_no),
        .col_dim_o      (col_dim),
        .w_mem_offset_o (w_mem_offset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: map = 0 layer_no, 1 ctrl, 4..11 act, 12..18 col, 19..25 woff
    int sh [0:25];
    int a_ln;
    int a_act [8];
    int a_col [7];
    int a_woff [7];
    bit m_err, m_pend;

    function automatic bit is_mapped(input int a);
        return (a == 0) || (a >= 4 && a <= 25);
    endfunction

    function automatic int mask_of(input int a);
        if (a == 0) return 7;
        if (a >= 19) return 1023;
        return 63;
    endfunction

    function automatic logic [30:0] exp_layers(input int li);
        int ia, oa, c, w;
        ia = (li < 8) ? a_act[li] : 0;
        oa = (li + 1 < 8) ? a_act[li+1] : 0;
        c  = (li < 7) ? a_col[li] : 0;
        w  = (li < 7) ? a_woff[li] : 0;
        return {3'(a_ln), 6'(ia), 6'(oa), 6'(c), 10'(w)};
    endfunction

    function automatic logic [30:0] got_layers();
        return {layer_no, in_act_no, out_act_no, col_dim, w_mem_offset};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 26; i++) sh[i] = 0;
        for (int i = 0; i < 8; i++) a_act[i] = 0;
        for (int i = 0; i < 7; i++) begin a_col[i] = 0; a_woff[i] = 0; end
        a_ln = 0; m_err = 0; m_pend = 0;
    endtask

    task automatic model_copy();
        a_ln = sh[0];
        for (int i = 0; i < 8; i++) a_act[i] = sh[4+i];
        for (int i = 0; i < 7; i++) begin a_col[i] = sh[12+i]; a_woff[i] = sh[19+i]; end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        bus.cfg_wr_valid = 1'b1;
        bus.cfg_wr_addr  = 6'(a);
        bus.cfg_wr_data  = 16'(d);
        n_checks++;
        if (bus.cfg_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ready addr=%0d got %b expected 1", a, bus.cfg_wr_ready);
        end
        @(negedge clk);
        bus.cfg_wr_valid = 1'b0;
        if (a == 1) begin
            if ((d & 2) != 0) m_err = 1'b0;
            if ((d & 1) != 0) m_pend = 1'b1;
        end else if (is_mapped(a)) begin
            sh[a] = d & mask_of(a);
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic rd(input int a);
        logic [15:0] exp;
        if (a == 1)            exp = {14'd0, m_err, m_pend};
        else if (is_mapped(a)) exp = 16'(sh[a]);
        else                   exp = 16'd0;
        @(negedge clk);
        bus.cfg_rd_valid = 1'b1;
        bus.cfg_rd_addr  = 6'(a);
        @(negedge clk);
        bus.cfg_rd_valid = 1'b0;
        n_checks++;
        if (bus.cfg_rd_data_valid !== 1'b1 || bus.cfg_rd_data !== exp) begin
            n_fail++;
            $display("FAIL readback addr=%0d got data=%h vld=%b expected data=%h vld=1",
                     a, bus.cfg_rd_data, bus.cfg_rd_data_valid, exp);
        end
        if (a != 1 && !is_mapped(a)) m_err = 1'b1;
    endtask

    // Commit with dp_busy held high for 'busy' cycles after the handshake
    task automatic do_commit(input int busy, input int ctrl);
        logic [30:0] old_l;
        bit ok;
        dp_busy = (busy > 0);
        wr(1, ctrl);
        old_l = exp_layers(int'(layer_idx));
        n_checks++;
        if (bus.cfg_wr_ready !== 1'b0 || commit_done !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_entry got ready=%b done=%b expected ready=0 done=0",
                     bus.cfg_wr_ready, commit_done);
        end
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.cfg_wr_ready !== 1'b0 || commit_done !== 1'b0 || got_layers() !== old_l) begin
                n_fail++;
                $display("FAIL pend_hold cyc=%0d got ready=%b done=%b layers=%h expected 0 0 %h",
                         i, bus.cfg_wr_ready, commit_done, got_layers(), old_l);
            end
        end
        dp_busy = 1'b0;
        @(negedge clk);
        ok = (sh[0] != 0) && (sh[0] <= 7);
        m_pend = 1'b0;
        n_checks++;
        if (commit_done !== ok || got_layers() !== old_l || cfg_err !== (m_err | !ok)) begin
            n_fail++;
            $display("FAIL commit_edge got done=%b err=%b layers=%h expected done=%b err=%b layers=%h",
                     commit_done, cfg_err, got_layers(), ok, m_err | !ok, old_l);
        end
        if (ok) model_copy();
        else    m_err = 1'b1;
        @(negedge clk);
        n_checks++;
        if (commit_done !== 1'b0 || bus.cfg_wr_ready !== 1'b1 ||
            got_layers() !== exp_layers(int'(layer_idx))) begin
            n_fail++;
            $display("FAIL commit_after got done=%b ready=%b layers=%h expected 0 1 %h",
                     commit_done, bus.cfg_wr_ready, got_layers(), exp_layers(int'(layer_idx)));
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.cfg_wr_ready !== 1'b1 || bus.cfg_rd_data_valid !== 1'b0 || bus.cfg_rd_data !== 16'd0 ||
            commit_done !== 1'b0 || cfg_err !== 1'b0 || got_layers() !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b rvld=%b rdata=%h done=%b err=%b layers=%h expected 1 0 0 0 0 0",
                     bus.cfg_wr_ready, bus.cfg_rd_data_valid, bus.cfg_rd_data, commit_done, cfg_err, got_layers());
        end
        for (int a = 0; a < 26; a++) if (a != 2 && a != 3) rd(a);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b expected 0", cfg_err);
        end
        wr(6, 37);
        rd(6);
        layer_idx = 3'd2;
        @(negedge clk);
        n_checks++;
        if (in_act_no !== 6'd0) begin
            n_fail++; $display("FAIL shadow_isolated in_act_no got %0d expected 0", in_act_no);
        end
    endtask

    task automatic test_commit_basic();
        wr(0, 3);
        wr(4, 10); wr(5, 20); wr(6, 30); wr(7, 40);
        wr(12, 5); wr(13, 6); wr(14, 7);
        wr(19, 0); wr(20, 100); wr(21, 200);
        do_commit(0, 1);
        layer_idx = 3'd1;
        @(negedge clk);
        n_checks++;
        if (in_act_no !== 6'd20 || out_act_no !== 6'd30 || col_dim !== 6'd6 ||
            w_mem_offset !== 10'd100 || layer_no !== 3'd3) begin
            n_fail++;
            $display("FAIL layer1 got in=%0d out=%0d col=%0d woff=%0d ln=%0d expected 20 30 6 100 3",
                     in_act_no, out_act_no, col_dim, w_mem_offset, layer_no);
        end
    endtask

    task automatic test_commit_busy();
        wr(5, 55);
        wr(13, 9);
        do_commit(5, 1);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (commit_done !== 1'b0) begin
                n_fail++; $display("FAIL done_single got %b expected 0", commit_done);
            end
        end
        n_checks++;
        if (in_act_no !== 6'd55 || col_dim !== 6'd9) begin
            n_fail++; $display("FAIL busy_commit got in=%0d col=%0d expected 55 9", in_act_no, col_dim);
        end
    endtask

    task automatic test_bad_commit();
        wr(0, 0);
        wr(6, 1);
        do_commit(0, 1);
        n_checks++;
        if (cfg_err !== 1'b1 || layer_no !== 3'd3 || out_act_no !== 6'd30) begin
            n_fail++;
            $display("FAIL bad_commit got err=%b ln=%0d out=%0d expected 1 3 30", cfg_err, layer_no, out_act_no);
        end
        wr(1, 2);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL clear_err got %b expected 0", cfg_err);
        end
        do_commit(1, 3);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL clear_then_commit_err got %b expected 1", cfg_err);
        end
        wr(1, 2);
        wr(0, 3);
    endtask

    task automatic test_boundary();
        wr(0, 7);
        wr(11, 63);
        layer_idx = 3'd7;
        do_commit(0, 1);
        n_checks++;
        if (in_act_no !== 6'd63 || out_act_no !== 6'd0 || col_dim !== 6'd0 || w_mem_offset !== 10'd0) begin
            n_fail++;
            $display("FAIL layer7 got in=%0d out=%0d col=%0d woff=%0d expected 63 0 0 0",
                     in_act_no, out_act_no, col_dim, w_mem_offset);
        end
        wr(26, 5);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL end_write_err got %b expected 1", cfg_err);
        end
        wr(1, 2);
        rd(2);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_read_err got %b expected 1", cfg_err);
        end
        wr(1, 2);
    endtask

    task automatic test_back_to_back();
        logic [15:0] old;
        old = 16'(sh[9]);
        @(negedge clk);
        bus.cfg_wr_valid = 1'b1; bus.cfg_wr_addr = 6'd9; bus.cfg_wr_data = 16'h002A;
        bus.cfg_rd_valid = 1'b1; bus.cfg_rd_addr = 6'd9;
        @(negedge clk);
        bus.cfg_wr_valid = 1'b0; bus.cfg_rd_valid = 1'b0;
        n_checks++;
        if (bus.cfg_rd_data !== old) begin
            n_fail++; $display("FAIL rw_same_cycle got %h expected old %h", bus.cfg_rd_data, old);
        end
        sh[9] = 16'h2A;
        rd(9);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.cfg_wr_valid = 1'b1; bus.cfg_wr_addr = 6'(15 + k); bus.cfg_wr_data = 16'(k * 7 + 3);
            n_checks++;
            if (bus.cfg_wr_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_ready k=%0d got %b expected 1", k, bus.cfg_wr_ready);
            end
        end
        @(negedge clk);
        bus.cfg_wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) sh[15 + k] = k * 7 + 3;
        for (int k = 0; k < 4; k++) rd(15 + k);
    endtask

    task automatic test_random();
        int op, a;
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 19));
            if (op < 8) begin
                a = int'($urandom_range(0, 22));
                a = (a == 0) ? 0 : a + 3;
                wr(a, int'($urandom & 32'hFFFF));
            end else if (op < 12) begin
                rd(int'($urandom_range(0, 63)));
            end else if (op < 15) begin
                layer_idx = 3'($urandom);
                @(negedge clk);
                n_checks++;
                if (got_layers() !== exp_layers(int'(layer_idx))) begin
                    n_fail++;
                    $display("FAIL rand_layers idx=%0d got %h expected %h",
                             layer_idx, got_layers(), exp_layers(int'(layer_idx)));
                end
            end else if (op < 17) begin
                do_commit(int'($urandom_range(0, 3)), 1);
            end else if (op == 17) begin
                wr(1, 2);
            end else begin
                a = int'($urandom_range(0, 39));
                a = (a < 2) ? a + 2 : a + 24;
                wr(a, int'($urandom & 32'hFFFF));
            end
            n_checks++;
            if (cfg_err !== m_err) begin
                n_fail++; $display("FAIL rand_err it=%0d got %b expected %b", it, cfg_err, m_err);
            end
        end
    endtask

    task automatic test_reset_pend();
        wr(0, 2);
        dp_busy = 1'b1;
        wr(1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (bus.cfg_wr_ready !== 1'b1 || bus.cfg_rd_data !== 16'd0 || bus.cfg_rd_data_valid !== 1'b0 ||
            commit_done !== 1'b0 || cfg_err !== 1'b0 || got_layers() !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_in_pend got rdy=%b rdata=%h rvld=%b done=%b err=%b layers=%h expected 1 0 0 0 0 0",
                     bus.cfg_wr_ready, bus.cfg_rd_data, bus.cfg_rd_data_valid, commit_done, cfg_err, got_layers());
        end
        @(negedge clk);
        rst_n = 1'b1;
        dp_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.cfg_wr_ready !== 1'b1 || commit_done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset got rdy=%b done=%b expected 1 0", bus.cfg_wr_ready, commit_done);
        end
        rd(1);
        rd(0);
    endtask

    initial begin
        bus.cfg_wr_valid = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.cfg_rd_valid = 1'b0; bus.cfg_rd_addr = '0;
        test_reset();
        test_commit_basic();
        test_commit_busy();
        test_bad_commit();
        test_boundary();
        test_back_to_back();
        test_random();
        test_reset_pend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
